// File: rtl/writeback_queue_pkg.sv
// Shared types and constants for the register-file write-back path.
package writeback_queue_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    // Initial value the register file loads into the stack pointer (x2).
    localparam logic [XLEN-1:0] STACK_PTR_RESET = 32'h0000_7ff0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/writeback_queue_if.sv
// Valid/ready write-back request channel from the datapath into the queue.
interface writeback_queue_if;
    import writeback_queue_pkg::*;

    logic                  wb_valid;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [XLEN-1:0]       wb_data;
    logic                  wb_ready;

    modport master (output wb_valid, output wb_rd, output wb_data, input wb_ready);
    modport slave  (input wb_valid, input wb_rd, input wb_data, output wb_ready);

endinterface

// File: rtl/writeback_queue_forward.sv
// Youngest-match search over the queued write-backs for one register read port.
module wbq_forward
    import writeback_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  wb_entry_t             entries [DEPTH],
    input  logic [PTR_W-1:0]      head,
    input  logic [PTR_W:0]        count,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [XLEN-1:0]       rf_dout,
    output logic [XLEN-1:0]       dout
);

    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] idx;

    // NOTE: blocking assignments in always_comb, each output defaulted first so no latch is inferred.
    always_comb begin
        dout = rf_dout;
        idx  = '0;
        // Walk oldest to youngest so the last hit (closest to tail) wins.
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (entries[idx].rd == rs)) begin
                dout = entries[idx].data;
            end
        end
        if (rs == '0) begin
            dout = '0;
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// Buffers write-back requests and drains one per cycle into the register file, forwarding queued data to reads.
module writeback_queue
    import writeback_queue_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    writeback_queue_if.slave      wb,
    input  logic                  hold,
    output logic [REG_ADDR_W-1:0] rd,
    output logic [XLEN-1:0]       rd_din,
    output logic                  write_enable,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic [XLEN-1:0]       rf_rs1_dout,
    input  logic [XLEN-1:0]       rf_rs2_dout,
    output logic [XLEN-1:0]       rs1_dout,
    output logic [XLEN-1:0]       rs2_dout,
    output logic [PTR_W:0]        pending_cnt
);

    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        entries [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             store;
    logic             pop;

    // Full is judged on the registered count only, so a pop never frees a slot in its own cycle.
    assign wb.wb_ready   = (count != CNT_W'(DEPTH));
    assign store         = wb.wb_valid && wb.wb_ready && (wb.wb_rd != '0);
    assign write_enable  = (count != '0) && !hold && !reset;
    assign pop           = write_enable;
    assign pending_cnt   = count;

    always_comb begin
        rd     = '0;
        rd_din = '0;
        if (count != '0) begin
            rd     = entries[head].rd;
            rd_din = entries[head].data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (store) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({store, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: entry storage has no reset; validity is tracked by head/tail/count alone.
    always_ff @(posedge clk) begin
        if (store) begin
            entries[tail] <= '{rd: wb.wb_rd, data: wb.wb_data};
        end
    end

    wbq_forward #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fwd_rs1 (
        .entries (entries),
        .head    (head),
        .count   (count),
        .rs      (rs1),
        .rf_dout (rf_rs1_dout),
        .dout    (rs1_dout)
    );

    wbq_forward #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fwd_rs2 (
        .entries (entries),
        .head    (head),
        .count   (count),
        .rs      (rs2),
        .rf_dout (rf_rs2_dout),
        .dout    (rs2_dout)
    );

endmodule

// File: tb/tb_writeback_queue.sv
// Scoreboard bench for writeback_queue: accepted requests are queued as expected register-file writes.
module tb_writeback_queue;
    import writeback_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int PTR_W = $clog2(DEPTH);

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  hold = 1'b0;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       rd_din;
    logic                  write_enable;
    logic [REG_ADDR_W-1:0] rs1 = '0;
    logic [REG_ADDR_W-1:0] rs2 = '0;
    logic [XLEN-1:0]       rf_rs1_dout = '0;
    logic [XLEN-1:0]       rf_rs2_dout = '0;
    logic [XLEN-1:0]       rs1_dout;
    logic [XLEN-1:0]       rs2_dout;
    logic [PTR_W:0]        pending_cnt;

    writeback_queue_if wb_if ();

    writeback_queue #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .wb           (wb_if),
        .hold         (hold),
        .rd           (rd),
        .rd_din       (rd_din),
        .write_enable (write_enable),
        .rs1          (rs1),
        .rs2          (rs2),
        .rf_rs1_dout  (rf_rs1_dout),
        .rf_rs2_dout  (rf_rs2_dout),
        .rs1_dout     (rs1_dout),
        .rs2_dout     (rs2_dout),
        .pending_cnt  (pending_cnt)
    );

    always #5 clk = ~clk;

    int        n_cmp = 0;
    int        n_err = 0;
    wb_entry_t sb[$];

    // Every register-file write must match the oldest outstanding accepted request.
    always @(negedge clk) begin
        if (!reset && write_enable === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: rd=%0d rd_din=%h, required no write", rd, rd_din);
            end else begin
                wb_entry_t exp;
                exp = sb.pop_front();
                if ({rd, rd_din} !== {exp.rd, exp.data}) begin
                    n_err++;
                    $display("FAIL drain_order: rd=%0d rd_din=%h, required rd=%0d rd_din=%h",
                             rd, rd_din, exp.rd, exp.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [REG_ADDR_W-1:0] r, input logic [XLEN-1:0] d);
        int waited = 0;
        wb_if.wb_valid = 1'b1;
        wb_if.wb_rd    = r;
        wb_if.wb_data  = d;
        while (wb_if.wb_ready !== 1'b1 && waited < 20) begin
            cycle();
            waited++;
        end
        if (wb_if.wb_ready !== 1'b1) begin
            n_cmp++; n_err++;
            $display("FAIL push_timeout: wb_ready=%b, required 1", wb_if.wb_ready);
        end else begin
            cycle();
            if (r != '0) sb.push_back('{rd: r, data: d});
        end
        wb_if.wb_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        hold = 1'b0;
        while (pending_cnt !== '0 && n < 50) begin
            cycle();
            n++;
        end
        n_cmp++;
        if (pending_cnt !== '0 || sb.size() != 0) begin
            n_err++;
            $display("FAIL drain_done: pending_cnt=%0d scoreboard=%0d, required 0/0", pending_cnt, sb.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle();
        n_cmp++; if (write_enable !== 1'b0) begin n_err++; $display("FAIL reset_we: %b, required 0", write_enable); end
        cycle();
        reset = 1'b0;
        rs1 = 5'd3; rf_rs1_dout = 32'h55;
        #1;
        n_cmp++; if (wb_if.wb_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: %b, required 1", wb_if.wb_ready); end
        n_cmp++; if (pending_cnt !== '0) begin n_err++; $display("FAIL reset_pending: %0d, required 0", pending_cnt); end
        n_cmp++; if ({rd, rd_din} !== '0) begin n_err++; $display("FAIL reset_rd: rd=%0d rd_din=%h, required 0/0", rd, rd_din); end
        n_cmp++; if (rs1_dout !== 32'h55) begin n_err++; $display("FAIL reset_fwd: %h, required 00000055", rs1_dout); end
    endtask

    task automatic test_latency();
        push(5'd5, 32'h1234);
        n_cmp++;
        if (write_enable !== 1'b1 || rd !== 5'd5 || rd_din !== 32'h1234) begin
            n_err++;
            $display("FAIL latency: we=%b rd=%0d rd_din=%h, required 1/5/00001234", write_enable, rd, rd_din);
        end
        cycle();
        n_cmp++; if (pending_cnt !== '0) begin n_err++; $display("FAIL latency_pop: pending=%0d, required 0", pending_cnt); end
    endtask

    task automatic test_fill_hold();
        hold = 1'b1;
        for (int k = 1; k <= 4; k++) push(REG_ADDR_W'(k), XLEN'(k * 32'h11));
        n_cmp++; if (wb_if.wb_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: %b, required 0", wb_if.wb_ready); end
        n_cmp++; if (pending_cnt !== 3'd4) begin n_err++; $display("FAIL full_pending: %0d, required 4", pending_cnt); end
        n_cmp++; if (write_enable !== 1'b0) begin n_err++; $display("FAIL hold_we: %b, required 0", write_enable); end
        hold = 1'b0;
        #1;
        n_cmp++; if (wb_if.wb_ready !== 1'b0) begin n_err++; $display("FAIL full_no_passthru: %b, required 0", wb_if.wb_ready); end
        for (int k = 1; k <= 4; k++) begin
            n_cmp++;
            if (write_enable !== 1'b1 || rd !== REG_ADDR_W'(k)) begin
                n_err++;
                $display("FAIL fill_order: we=%b rd=%0d, required 1/%0d", write_enable, rd, k);
            end
            cycle();
            if (k == 1) begin
                n_cmp++; if (wb_if.wb_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_pop: %b, required 1", wb_if.wb_ready); end
            end
        end
        drain();
    endtask

    task automatic test_forwarding();
        hold = 1'b1;
        push(5'd7, 32'hA);
        push(5'd7, 32'hB);
        rs1 = 5'd7; rf_rs1_dout = 32'hFFFF;
        rs2 = 5'd8; rf_rs2_dout = 32'h2222;
        #1;
        n_cmp++; if (rs1_dout !== 32'hB) begin n_err++; $display("FAIL fwd_youngest: %h, required 0000000b", rs1_dout); end
        n_cmp++; if (rs2_dout !== 32'h2222) begin n_err++; $display("FAIL fwd_miss: %h, required 00002222", rs2_dout); end
        wb_if.wb_valid = 1'b1; wb_if.wb_rd = 5'd8; wb_if.wb_data = 32'h88;
        #1;
        n_cmp++; if (rs2_dout !== 32'h2222) begin n_err++; $display("FAIL fwd_inflight: %h, required 00002222", rs2_dout); end
        cycle();
        wb_if.wb_valid = 1'b0;
        sb.push_back('{rd: 5'd8, data: 32'h88});
        n_cmp++; if (rs2_dout !== 32'h88) begin n_err++; $display("FAIL fwd_queued: %h, required 00000088", rs2_dout); end
        rs1 = 5'd0;
        #1;
        n_cmp++; if (rs1_dout !== '0) begin n_err++; $display("FAIL fwd_x0: %h, required 0", rs1_dout); end
        rs1 = 5'd7;
        hold = 1'b0;
        #1;
        n_cmp++; if (rs1_dout !== 32'hB) begin n_err++; $display("FAIL fwd_draining: %h, required 0000000b", rs1_dout); end
        drain();
        n_cmp++; if (rs1_dout !== 32'hFFFF) begin n_err++; $display("FAIL fwd_empty: %h, required 0000ffff", rs1_dout); end
    endtask

    task automatic test_x0_drop();
        wb_if.wb_valid = 1'b1; wb_if.wb_rd = 5'd0; wb_if.wb_data = 32'hDEAD;
        #1;
        n_cmp++; if (wb_if.wb_ready !== 1'b1) begin n_err++; $display("FAIL x0_ready: %b, required 1", wb_if.wb_ready); end
        cycle();
        wb_if.wb_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (pending_cnt !== '0 || write_enable !== 1'b0) begin
                n_err++;
                $display("FAIL x0_drop: pending=%0d we=%b, required 0/0", pending_cnt, write_enable);
            end
            cycle();
        end
    endtask

    task automatic test_simultaneous();
        hold = 1'b1;
        for (int k = 0; k < 3; k++) push(REG_ADDR_W'(10 + k), 32'h1000 + XLEN'(k));
        hold = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wb_if.wb_valid = 1'b1; wb_if.wb_rd = REG_ADDR_W'(13 + k); wb_if.wb_data = 32'h2000 + XLEN'(k);
            #1;
            n_cmp++; if (wb_if.wb_ready !== 1'b1 || write_enable !== 1'b1) begin n_err++; $display("FAIL simul_hs: ready=%b we=%b, required 1/1", wb_if.wb_ready, write_enable); end
            cycle();
            sb.push_back('{rd: REG_ADDR_W'(13 + k), data: 32'h2000 + XLEN'(k)});
            n_cmp++; if (pending_cnt !== 3'd3) begin n_err++; $display("FAIL simul_count: %0d, required 3", pending_cnt); end
        end
        wb_if.wb_valid = 1'b0;
        drain();
    endtask

    task automatic test_reset_mid();
        hold = 1'b1;
        for (int k = 0; k < 3; k++) push(REG_ADDR_W'(20 + k), 32'hC0DE_0000 + XLEN'(k));
        hold = 1'b0;
        reset = 1'b1;
        sb.delete();
        #1;
        n_cmp++; if (write_enable !== 1'b0) begin n_err++; $display("FAIL reset_mid_we: %b, required 0", write_enable); end
        cycle();
        reset = 1'b0;
        #1;
        n_cmp++; if (pending_cnt !== '0 || wb_if.wb_ready !== 1'b1) begin n_err++; $display("FAIL reset_mid_state: pending=%0d ready=%b, required 0/1", pending_cnt, wb_if.wb_ready); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (write_enable !== 1'b0 || rd_din !== '0) begin
                n_err++;
                $display("FAIL reset_mid_discard: we=%b rd_din=%h, required 0/0", write_enable, rd_din);
            end
            cycle();
        end
    endtask

    initial begin
        wb_if.wb_valid = 1'b0;
        wb_if.wb_rd    = '0;
        wb_if.wb_data  = '0;
        test_reset();
        test_latency();
        test_fill_hold();
        test_forwarding();
        test_x0_drop();
        test_simultaneous();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
